// File: rtl/axi_stream_slave.sv
// axi_stream_slave
// AXI4-Stream receiver with a small first-word-fall-through buffer and
// packet tracking (ID/destination latch, beat count, end pulse, protocol error).
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser/twakeup
//                          AXI4-Stream sink (tstrb, twakeup unused)
//   data_out/keep_out/user_out/last_out/valid_out
//                          head-of-FIFO beat, zero when empty
//   read                   pop head when valid_out=1
//   pkt_id/pkt_dest        tid/tdest latched at the first beat of a packet
//   beat_count             non-null beats of current packet, saturating
//   pkt_done               one-cycle pulse after a tlast beat is accepted
//   proto_err              sticky tid/tdest mismatch inside a packet
//
// state   | meaning
// ST_IDLE | between packets, next transfer starts a packet
// ST_RECV | inside a packet, checking tid/tdest against latched values
module axi_stream_slave #(
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       tvalid,
  output logic                       tready,
  input  logic [TDATA_WIDTH-1:0]     tdata,
  input  logic [TDATA_WIDTH/8-1:0]   tstrb,
  input  logic [TDATA_WIDTH/8-1:0]   tkeep,
  input  logic                       tlast,
  input  logic [TID_WIDTH-1:0]       tid,
  input  logic [TDEST_WIDTH-1:0]     tdest,
  input  logic [TUSER_WIDTH-1:0]     tuser,
  input  logic                       twakeup,
  output logic [TDATA_WIDTH-1:0]     data_out,
  output logic [TDATA_WIDTH/8-1:0]   keep_out,
  output logic [TUSER_WIDTH-1:0]     user_out,
  output logic                       last_out,
  output logic                       valid_out,
  input  logic                       read,
  output logic [TID_WIDTH-1:0]       pkt_id,
  output logic [TDEST_WIDTH-1:0]     pkt_dest,
  output logic [CNT_WIDTH-1:0]       beat_count,
  output logic                       pkt_done,
  output logic                       proto_err
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam logic [OW-1:0]        DEPTH_C = OW'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ST_IDLE, ST_RECV} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic                    rdy_en_q;
  logic [TID_WIDTH-1:0]    pkt_id_q, pkt_id_d;
  logic [TDEST_WIDTH-1:0]  pkt_dest_q, pkt_dest_d;
  logic [CNT_WIDTH-1:0]    beat_count_q, beat_count_d;
  logic                    pkt_done_q, pkt_done_d;
  logic                    proto_err_q, proto_err_d;

  logic [TDATA_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
  logic [KW-1:0]           keep_mem_q [FIFO_DEPTH];
  logic [TUSER_WIDTH-1:0]  user_mem_q [FIFO_DEPTH];
  logic                    last_mem_q [FIFO_DEPTH];

  logic xfer, null_beat, push, pop;
  logic unused_ok;

  assign unused_ok = ^{tstrb, twakeup};

  // rdy_en_q keeps tready low through reset and for the release cycle,
  // since occupancy alone would already read as "not full" during reset.
  assign tready    = rdy_en_q && (occ_q < DEPTH_C);
  assign valid_out = (occ_q != '0);

  assign xfer      = tvalid && tready;
  assign null_beat = (tkeep == '0);
  // A null beat carrying tlast is still stored so the consumer sees the end.
  assign push      = xfer && !(null_beat && !tlast);
  assign pop       = read && valid_out;

  assign data_out  = valid_out ? data_mem_q[rd_ptr_q] : '0;
  assign keep_out  = valid_out ? keep_mem_q[rd_ptr_q] : '0;
  assign user_out  = valid_out ? user_mem_q[rd_ptr_q] : '0;
  assign last_out  = valid_out ? last_mem_q[rd_ptr_q] : 1'b0;

  assign pkt_id     = pkt_id_q;
  assign pkt_dest   = pkt_dest_q;
  assign beat_count = beat_count_q;
  assign pkt_done   = pkt_done_q;
  assign proto_err  = proto_err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pkt_id_d     = pkt_id_q;
    pkt_dest_d   = pkt_dest_q;
    beat_count_d = beat_count_q;
    pkt_done_d   = 1'b0;
    proto_err_d  = proto_err_q;
    if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          pkt_id_d     = tid;
          pkt_dest_d   = tdest;
          beat_count_d = null_beat ? '0 : CNT_WIDTH'(1);
          pkt_done_d   = tlast;
          state_d      = tlast ? ST_IDLE : ST_RECV;
        end
        ST_RECV: begin
          if (!null_beat && (beat_count_q != CNT_MAX))
            beat_count_d = beat_count_q + CNT_WIDTH'(1);
          if ((tid != pkt_id_q) || (tdest != pkt_dest_q))
            proto_err_d = 1'b1;
          if (tlast) begin
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      rdy_en_q     <= 1'b0;
      pkt_id_q     <= '0;
      pkt_dest_q   <= '0;
      beat_count_q <= '0;
      pkt_done_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      rdy_en_q     <= 1'b1;
      pkt_id_q     <= pkt_id_d;
      pkt_dest_q   <= pkt_dest_d;
      beat_count_q <= beat_count_d;
      pkt_done_q   <= pkt_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Storage is not reset; outputs are masked by valid_out instead.
  always_ff @(posedge aclk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= tdata;
      keep_mem_q[wr_ptr_q] <= tkeep;
      user_mem_q[wr_ptr_q] <= tuser;
      last_mem_q[wr_ptr_q] <= tlast;
    end
  end

endmodule

// File: tb/tb_axi_stream_slave.sv
module tb_axi_stream_slave;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [DW-1:0] tdata = '0;
  logic [KW-1:0] tstrb = '0;
  logic [KW-1:0] tkeep = '0;
  logic          tlast = 1'b0;
  logic [7:0]    tid = '0;
  logic [7:0]    tdest = '0;
  logic [7:0]    tuser = '0;
  logic          twakeup = 1'b0;
  logic [DW-1:0] data_out;
  logic [KW-1:0] keep_out;
  logic [7:0]    user_out;
  logic          last_out;
  logic          valid_out;
  logic          read = 1'b0;
  logic [7:0]    pkt_id;
  logic [7:0]    pkt_dest;
  logic [15:0]   beat_count;
  logic          pkt_done;
  logic          proto_err;

  axi_stream_slave #(
    .TDATA_WIDTH(DW), .TID_WIDTH(8), .TDEST_WIDTH(8), .TUSER_WIDTH(8),
    .FIFO_DEPTH(4), .CNT_WIDTH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
    .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
    .twakeup(twakeup),
    .data_out(data_out), .keep_out(keep_out), .user_out(user_out),
    .last_out(last_out), .valid_out(valid_out), .read(read),
    .pkt_id(pkt_id), .pkt_dest(pkt_dest), .beat_count(beat_count),
    .pkt_done(pkt_done), .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic          v;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [7:0]    tid;
    logic          rd;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic [KW-1:0] e_keep;
    logic          e_last;
    logic [15:0]   e_bc;
    logic [7:0]    e_pid;
    logic          e_done;
    logic          e_perr;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  string ctx = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", ctx, name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [DW-1:0] data, input logic [KW-1:0] keep,
                     input logic last, input logic [7:0] id, input logic rd,
                     input logic e_rdy, input logic e_vld, input logic [DW-1:0] e_data,
                     input logic [KW-1:0] e_keep, input logic e_last, input logic [15:0] e_bc,
                     input logic [7:0] e_pid, input logic e_done, input logic e_perr);
    vec_t r;
    r.v = v; r.data = data; r.keep = keep; r.last = last; r.tid = id; r.rd = rd;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_data = e_data; r.e_keep = e_keep;
    r.e_last = e_last; r.e_bc = e_bc; r.e_pid = e_pid; r.e_done = e_done; r.e_perr = e_perr;
    vecs.push_back(r);
  endtask

  // tdest and tuser are derived from tid/tdata so they need no table columns.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic [7:0] id, input logic rd);
    tvalid = v; tdata = d; tkeep = k; tlast = l; tid = id;
    tdest = id ^ 8'h10; tuser = d[7:0] ^ 8'h5A; tstrb = ~k; read = rd;
  endtask

  initial begin
    //  v  data          keep  lst tid  rd | rdy vld e_data       e_keep l  bc  pid dn pe
    // single beat, read held
    add(1, 32'hA5A5A5A5, 4'hF, 1, 8'd3, 1,  1, 1, 32'hA5A5A5A5, 4'hF, 1, 1, 8'd3, 1, 0);
    add(0, 32'h0,        4'h0, 0, 8'd3, 1,  1, 0, 32'h0,        4'h0, 0, 1, 8'd3, 0, 0);
    // fill to depth, then stall, then drain in order
    add(1, 32'h11111111, 4'hF, 0, 8'd4, 0,  1, 1, 32'h11111111, 4'hF, 0, 1, 8'd4, 0, 0);
    add(1, 32'h22222222, 4'hF, 0, 8'd4, 0,  1, 1, 32'h11111111, 4'hF, 0, 2, 8'd4, 0, 0);
    add(1, 32'h33333333, 4'hF, 0, 8'd4, 0,  1, 1, 32'h11111111, 4'hF, 0, 3, 8'd4, 0, 0);
    add(1, 32'h44444444, 4'hF, 1, 8'd4, 0,  0, 1, 32'h11111111, 4'hF, 0, 4, 8'd4, 1, 0);
    add(1, 32'h55555555, 4'hF, 0, 8'd6, 0,  0, 1, 32'h11111111, 4'hF, 0, 4, 8'd4, 0, 0);
    add(1, 32'h55555555, 4'hF, 0, 8'd6, 1,  1, 1, 32'h22222222, 4'hF, 0, 4, 8'd4, 0, 0);
    add(1, 32'h55555555, 4'hF, 0, 8'd6, 1,  1, 1, 32'h33333333, 4'hF, 0, 1, 8'd6, 0, 0);
    add(1, 32'h66666666, 4'hF, 1, 8'd6, 1,  1, 1, 32'h44444444, 4'hF, 1, 2, 8'd6, 1, 0);
    add(0, 32'h0,        4'h0, 0, 8'd6, 1,  1, 1, 32'h55555555, 4'hF, 0, 2, 8'd6, 0, 0);
    add(0, 32'h0,        4'h0, 0, 8'd6, 1,  1, 1, 32'h66666666, 4'hF, 1, 2, 8'd6, 0, 0);
    add(0, 32'h0,        4'h0, 0, 8'd6, 1,  1, 0, 32'h0,        4'h0, 0, 2, 8'd6, 0, 0);
    // streaming with read every cycle
    add(1, 32'h77777777, 4'hF, 0, 8'd7, 1,  1, 1, 32'h77777777, 4'hF, 0, 1, 8'd7, 0, 0);
    add(1, 32'h88888888, 4'hF, 0, 8'd7, 1,  1, 1, 32'h88888888, 4'hF, 0, 2, 8'd7, 0, 0);
    add(1, 32'h99999999, 4'hF, 1, 8'd7, 1,  1, 1, 32'h99999999, 4'hF, 1, 3, 8'd7, 1, 0);
    add(0, 32'h0,        4'h0, 0, 8'd7, 1,  1, 0, 32'h0,        4'h0, 0, 3, 8'd7, 0, 0);
    // null beat in the middle of a packet
    add(1, 32'hAAAA0001, 4'hF, 0, 8'd2, 0,  1, 1, 32'hAAAA0001, 4'hF, 0, 1, 8'd2, 0, 0);
    add(1, 32'hAAAA0002, 4'h0, 0, 8'd2, 0,  1, 1, 32'hAAAA0001, 4'hF, 0, 1, 8'd2, 0, 0);
    add(1, 32'hAAAA0003, 4'h3, 1, 8'd2, 0,  1, 1, 32'hAAAA0001, 4'hF, 0, 2, 8'd2, 1, 0);
    add(0, 32'h0,        4'h0, 0, 8'd2, 1,  1, 1, 32'hAAAA0003, 4'h3, 1, 2, 8'd2, 0, 0);
    add(0, 32'h0,        4'h0, 0, 8'd2, 1,  1, 0, 32'h0,        4'h0, 0, 2, 8'd2, 0, 0);
    // tid change mid-packet, error sticks through a clean packet
    add(1, 32'h000000C1, 4'hF, 0, 8'd3, 1,  1, 1, 32'h000000C1, 4'hF, 0, 1, 8'd3, 0, 0);
    add(1, 32'h000000C2, 4'hF, 0, 8'd5, 1,  1, 1, 32'h000000C2, 4'hF, 0, 2, 8'd3, 0, 1);
    add(1, 32'h000000C3, 4'hF, 1, 8'd3, 1,  1, 1, 32'h000000C3, 4'hF, 1, 3, 8'd3, 1, 1);
    add(1, 32'h000000D1, 4'hF, 1, 8'd8, 1,  1, 1, 32'h000000D1, 4'hF, 1, 1, 8'd8, 1, 1);
    // null beat with tlast: stored, counts zero beats
    add(1, 32'h000000E0, 4'h0, 1, 8'd9, 1,  1, 1, 32'h000000E0, 4'h0, 1, 0, 8'd9, 1, 1);
    add(0, 32'h0,        4'h0, 0, 8'd9, 1,  1, 0, 32'h0,        4'h0, 0, 0, 8'd9, 0, 1);

    // reset state
    drive(0, '0, '0, 0, 8'd0, 0);
    repeat (2) @(posedge aclk);
    #1;
    ctx = "reset";
    chk("tready", tready, 0);
    chk("valid_out", valid_out, 0);
    chk("data_out", data_out, 0);
    chk("last_out", last_out, 0);
    chk("pkt_id", pkt_id, 0);
    chk("beat_count", beat_count, 0);
    chk("pkt_done", pkt_done, 0);
    chk("proto_err", proto_err, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    ctx = "release";
    chk("tready", tready, 1);
    chk("valid_out", valid_out, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].tid, vecs[i].rd);
      @(posedge aclk);
      #1;
      ctx = $sformatf("row%0d", i);
      chk("tready", tready, vecs[i].e_rdy);
      chk("valid_out", valid_out, vecs[i].e_vld);
      chk("data_out", data_out, vecs[i].e_data);
      chk("keep_out", keep_out, vecs[i].e_keep);
      chk("user_out", user_out, vecs[i].e_vld ? (vecs[i].e_data[7:0] ^ 8'h5A) : 8'h00);
      chk("last_out", last_out, vecs[i].e_last);
      chk("beat_count", beat_count, vecs[i].e_bc);
      chk("pkt_id", pkt_id, vecs[i].e_pid);
      chk("pkt_dest", pkt_dest, vecs[i].e_pid ^ 8'h10);
      chk("pkt_done", pkt_done, vecs[i].e_done);
      chk("proto_err", proto_err, vecs[i].e_perr);
    end

    // reset with three beats buffered
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hF0F0F000 + i, 4'hF, 0, 8'd1, 0);
      @(posedge aclk);
      #1;
    end
    drive(0, '0, '0, 0, 8'd0, 0);
    ctx = "buffered";
    chk("valid_out", valid_out, 1);
    chk("data_out", data_out, 32'hF0F0F000);
    chk("beat_count", beat_count, 3);
    #2;
    aresetn = 1'b0;
    #1;
    ctx = "midreset";
    chk("valid_out", valid_out, 0);
    chk("tready", tready, 0);
    chk("data_out", data_out, 0);
    chk("beat_count", beat_count, 0);
    chk("proto_err", proto_err, 0);
    chk("pkt_id", pkt_id, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("tready_release", tready, 0);
    @(posedge aclk);
    #1;
    ctx = "after_reset";
    chk("tready", tready, 1);
    chk("valid_out", valid_out, 0);
    chk("beat_count", beat_count, 0);
    chk("proto_err", proto_err, 0);
    // a fresh beat after reset lands at the head of an empty FIFO
    drive(1, 32'h12345678, 4'hF, 1, 8'd4, 0);
    @(posedge aclk);
    #1;
    drive(0, '0, '0, 0, 8'd0, 0);
    ctx = "post_reset_beat";
    chk("data_out", data_out, 32'h12345678);
    chk("beat_count", beat_count, 1);
    chk("pkt_done", pkt_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
